// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero de-stuffing and LSB-first
// byte assembly from a serial line carrying one bit per enabled clock.
//
// Handshake: there is no backpressure. Rx_FlagDetect, Rx_AbortDetect,
// Rx_NewByte, Rx_FrameEnd and Rx_FrameError are single-clock pulses that the
// consumer must take when they occur. Rx_Data is valid while Rx_NewByte is high
// and then holds until the next byte. Rx_ValidFrame is a level.
module hdlc_rx_deframer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       Rx_Enable,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FrameEnd,
    output logic       Rx_FrameError
);
    // Bits leave the delay line 8 samples late, so a flag is recognised while
    // all of its own bits are still inside the line and none reach the byte.
    localparam int DELAY_DEPTH = 8;

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             shr_q, shr_d;
    logic [2:0]             ones_q, ones_d;
    logic                   new_q;
    logic                   abort_pend_q, abort_pend_d;
    logic [DELAY_DEPTH-1:0] dly_bit_q, dly_bit_d;
    logic [DELAY_DEPTH-1:0] dly_keep_q, dly_keep_d;
    logic [7:0]             byte_q, byte_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic                   has_bits_q, has_bits_d;
    logic [7:0]             data_q, data_d;
    logic                   newbyte_q, newbyte_d;
    logic                   flag_q, abort_q;
    logic                   fend_q, fend_d;
    logic                   ferr_q, ferr_d;
    logic                   stuffed;
    logic                   assemble;
    logic                   flag_hit, abort_hit;
    logic                   exit_bit, exit_keep;

    // Pattern compares run once, in the clock after each new sample.
    assign flag_hit  = new_q && (shr_q == 8'h7E);
    assign abort_hit = new_q && abort_pend_q;
    assign exit_bit  = dly_bit_q[DELAY_DEPTH-1];
    assign exit_keep = dly_keep_q[DELAY_DEPTH-1];

    // Line sampling: shift register, ones run counter and the bit/keep delay line.
    always_comb begin
        shr_d        = shr_q;
        ones_d       = ones_q;
        abort_pend_d = abort_pend_q;
        dly_bit_d    = dly_bit_q;
        dly_keep_d   = dly_keep_q;
        stuffed      = !Rx && (ones_q == 3'd5);
        if (Rx_Enable) begin
            shr_d        = {shr_q[6:0], Rx};
            ones_d       = Rx ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
            abort_pend_d = Rx && (ones_q == 3'd6);
            dly_bit_d    = {dly_bit_q[DELAY_DEPTH-2:0], Rx};
            dly_keep_d   = {dly_keep_q[DELAY_DEPTH-2:0], !stuffed};
        end
        // A flag's bits sit in the line; keep only a sample taken this very cycle.
        if (flag_hit) begin
            dly_keep_d = dly_keep_d & DELAY_DEPTH'(Rx_Enable);
        end
    end

    // Frame state: next state, frame-end reporting and the byte-assembly enable.
    always_comb begin
        state_d  = state_q;
        assemble = 1'b0;
        fend_d   = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (flag_hit) state_d = FRAME;
            end
            FRAME: begin
                if (abort_hit) begin
                    state_d = IDLE;
                end else if (flag_hit) begin
                    fend_d = has_bits_q;
                    ferr_d = has_bits_q && (bitcnt_q != 3'd0);
                end else begin
                    assemble = Rx_Enable && exit_keep;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte assembly: shift right from the MSB end, publish on every 8th bit.
    always_comb begin
        byte_d     = byte_q;
        bitcnt_d   = bitcnt_q;
        has_bits_d = has_bits_q;
        data_d     = data_q;
        newbyte_d  = 1'b0;
        if (flag_hit || abort_hit) begin
            bitcnt_d   = 3'd0;
            has_bits_d = 1'b0;
        end else if (assemble) begin
            byte_d     = {exit_bit, byte_q[7:1]};
            bitcnt_d   = bitcnt_q + 3'd1;
            has_bits_d = 1'b1;
            if (bitcnt_q == 3'd7) begin
                data_d    = byte_d;
                newbyte_d = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Datapath registers and registered output pulses.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            shr_q        <= '0;
            ones_q       <= '0;
            new_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            dly_bit_q    <= '0;
            dly_keep_q   <= '0;
            byte_q       <= '0;
            bitcnt_q     <= '0;
            has_bits_q   <= 1'b0;
            data_q       <= '0;
            newbyte_q    <= 1'b0;
            flag_q       <= 1'b0;
            abort_q      <= 1'b0;
            fend_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            shr_q        <= shr_d;
            ones_q       <= ones_d;
            new_q        <= Rx_Enable;
            abort_pend_q <= abort_pend_d;
            dly_bit_q    <= dly_bit_d;
            dly_keep_q   <= dly_keep_d;
            byte_q       <= byte_d;
            bitcnt_q     <= bitcnt_d;
            has_bits_q   <= has_bits_d;
            data_q       <= data_d;
            newbyte_q    <= newbyte_d;
            flag_q       <= flag_hit;
            abort_q      <= abort_hit;
            fend_q       <= fend_d;
            ferr_q       <= ferr_d;
        end
    end

    assign Rx_FlagDetect  = flag_q;
    assign Rx_AbortDetect = abort_q;
    assign Rx_ValidFrame  = (state_q == FRAME);
    assign Rx_Data        = data_q;
    assign Rx_NewByte     = newbyte_q;
    assign Rx_FrameEnd    = fend_q;
    assign Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Testbench for hdlc_rx_deframer: directed frames plus random frames, with a
// line-level reference model feeding an expected-event queue and an
// independent monitor comparing every output pulse, its cycle and its data.
module tb_hdlc_rx_deframer;
    localparam int W = 46;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic       Rx_Enable;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_ValidFrame;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_FrameEnd;
    logic       Rx_FrameError;

    hdlc_rx_deframer dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Rx            (Rx),
        .Rx_Enable     (Rx_Enable),
        .Rx_FlagDetect (Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_ValidFrame (Rx_ValidFrame),
        .Rx_Data       (Rx_Data),
        .Rx_NewByte    (Rx_NewByte),
        .Rx_FrameEnd   (Rx_FrameEnd),
        .Rx_FrameError (Rx_FrameError)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // Event word: {cycle[31:0], kind, flag, abort, fend, ferr, valid, data[7:0]}
    logic [W-1:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [W-1:0] mk(input int c, input logic kind, input logic flg,
                                        input logic abt, input logic fe, input logic fr,
                                        input logic vld, input logic [7:0] d);
        return {32'(c), kind, flg, abt, fe, fr, vld, d};
    endfunction

    task automatic compare_evt(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got cyc=%0d word=%h, expected no event", name, act[45:14], act[13:0]);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: got cyc=%0d word=%h, expected cyc=%0d word=%h",
                         name, act[45:14], act[13:0], e[45:14], e[13:0]);
            end
        end
    endtask

    task automatic check_zero(input string name);
        logic [13:0] act;
        act = {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte,
               Rx_FrameEnd, Rx_FrameError, Rx_Data};
        vectors++;
        if (act !== 14'd0) begin
            miscompares++;
            $display("FAIL %s: outputs got %h, expected 0", name, act);
        end
    endtask

    // ---------------- reference model (line-level rules) ----------------
    int         m_run;
    logic [7:0] m_hist;
    logic [1:0] m_line[$];   // {bit, keep}, oldest first
    bit         m_in_frame;
    int         m_cnt;
    int         m_total;
    logic [7:0] m_byte;
    logic [7:0] m_last;

    task automatic model_reset();
        m_run = 0; m_hist = 8'h00; m_line.delete(); m_in_frame = 0;
        m_cnt = 0; m_total = 0; m_byte = 8'h00; m_last = 8'h00;
    endtask

    task automatic model_step(input logic b, input int c);
        logic [1:0] e;
        bit stuffed, abort, flag, fe;
        stuffed = (b == 1'b0) && (m_run == 5);
        m_line.push_back({b, !stuffed});
        if (m_line.size() > 8) begin
            e = m_line.pop_front();
            if (m_in_frame && e[0]) begin
                m_byte[m_cnt] = e[1];
                m_cnt++;
                m_total++;
                if (m_cnt == 8) begin
                    m_last = m_byte;
                    exp_q.push_back(mk(c + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_byte));
                    m_cnt = 0;
                end
            end
        end
        abort  = (b == 1'b1) && (m_run == 6);
        m_run  = b ? ((m_run < 7) ? m_run + 1 : 7) : 0;
        m_hist = {m_hist[6:0], b};
        flag   = (m_hist == 8'h7E);
        if (flag) begin
            fe = m_in_frame && (m_total > 0);
            exp_q.push_back(mk(c + 2, 1'b1, 1'b1, 1'b0, fe, fe && (m_cnt != 0), 1'b1, m_last));
            m_in_frame = 1; m_line.delete(); m_cnt = 0; m_total = 0;
        end
        if (abort) begin
            exp_q.push_back(mk(c + 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_last));
            m_in_frame = 0; m_cnt = 0; m_total = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    int gap_mode = 0;   // 0 continuous, 1 random gaps, 2 strict 1/0 toggling
    int tx_ones  = 0;

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            Rx        = 1'($urandom_range(0, 1));
            Rx_Enable = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        if (gap_mode == 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        @(negedge Clk);
        Rx        = b;
        Rx_Enable = 1'b1;
        model_step(b, cyc);
        if (gap_mode == 2) idle(1);
    endtask

    task automatic send_data_bit(input logic b);
        send_bit(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                send_bit(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_data_bit(d[i]);
    endtask

    task automatic send_flag();
        send_bit(1'b0);
        repeat (6) send_bit(1'b1);
        send_bit(1'b0);
        tx_ones = 0;
    endtask

    task automatic send_abort();
        send_bit(1'b0);
        repeat (7) send_bit(1'b1);
        tx_ones = 0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge Clk);
            if (Rx_NewByte === 1'b1)
                compare_evt("newbyte", mk(cyc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Rx_ValidFrame, Rx_Data));
            if (Rx_FlagDetect === 1'b1 || Rx_AbortDetect === 1'b1 ||
                Rx_FrameEnd === 1'b1 || Rx_FrameError === 1'b1)
                compare_evt("ctrl", mk(cyc, 1'b1, Rx_FlagDetect, Rx_AbortDetect, Rx_FrameEnd,
                                       Rx_FrameError, Rx_ValidFrame, Rx_Data));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int nb;
        int nx;
        Rst = 1'b0; Rx = 1'b1; Rx_Enable = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_zero("reset_outputs");
        Rst = 1'b1;
        idle(2);
        check_zero("after_reset_idle");

        // Idle line of ones: one abort pulse, no repeat while saturated.
        repeat (10) send_bit(1'b1);

        send_flag(); send_byte(8'hA5); send_flag();
        send_flag(); send_byte(8'hFF); send_flag();
        send_flag(); send_byte(8'h3C); send_abort();
        send_flag(); send_byte(8'h5A); send_flag();
        send_flag(); send_byte(8'h12);
        send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
        send_flag();

        // Reset in the middle of a byte drops the frame.
        send_flag();
        for (int i = 0; i < 4; i++) send_data_bit(1'(8'h55 >> i));
        idle(4);
        Rst = 1'b0;
        model_reset();
        tx_ones = 0;
        #1 check_zero("reset_async_mid_frame");
        idle(2);
        check_zero("reset_held_mid_frame");
        Rst = 1'b1;
        idle(1);
        send_flag(); send_byte(8'h66); send_flag();

        // Enable toggling every clock.
        gap_mode = 2;
        send_flag(); send_byte(8'h81); send_flag();
        gap_mode = 0;

        // Random frames: varying lengths, residual bits, aborts, enable gaps.
        for (int f = 0; f < 40; f++) begin
            gap_mode = $urandom_range(0, 1);
            send_flag();
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                nx = $urandom_range(1, 7);
                for (int k = 0; k < nx; k++) send_data_bit(1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 5) == 0) send_abort();
            else                           send_flag();
        end
        gap_mode = 0;
        idle(6);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_deframer.md
Name: hdlc_rx_deframer

Overview:
Serial front end of the HDLC receive path. It samples the line bit stream, detects flags (01111110) and aborts (0 followed by 7 ones), and removes stuffed zeros. It assembles de-stuffed payload bits LSB-first into bytes and reports frame boundaries and errors to the downstream Rx buffer/control stage. One line bit per enabled clock.

Parameters:
DELAY_DEPTH, 8, bit delay line length; data bits leave the line this many enabled cycles after sampling, so flag bits are never emitted as payload (fixed at 8, not to be overridden)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous active-low reset
Rx  in  1  serial line bit, sampled when Rx_Enable=1
Rx_Enable  in  1  bit strobe; when 0 all state holds
Rx_FlagDetect  out  1  one-cycle pulse on flag
Rx_AbortDetect  out  1  one-cycle pulse on abort pattern
Rx_ValidFrame  out  1  high while inside a frame
Rx_Data  out  8  last assembled byte, bit0 = first received
Rx_NewByte  out  1  one-cycle pulse, Rx_Data valid
Rx_FrameEnd  out  1  one-cycle pulse when a closing flag ends a non-empty frame
Rx_FrameError  out  1  one-cycle pulse with Rx_FrameEnd if payload bit count mod 8 != 0

Behaviour:
- Reset (Rst=0, async): all outputs 0, shift/delay lines 0, ones counter 0, state IDLE. Reset mid-frame drops the partial frame; no FrameEnd is issued.
- Cycle E0: enabled cycle in which Rx is sampled into 8-bit shift register shr (newest at bit0).
- Ones counter: increments on Rx=1, saturates at 7, clears on Rx=0.
- Flag: shr time-ordered = 0,1,1,1,1,1,1,0, with final 0 sampled at E0 -> registered compare -> Rx_FlagDetect=1 at E0+2 clocks (Rx_Enable held 1).
- Abort: ones counter reaches 7 -> Rx_AbortDetect=1 at E0+2. One pulse per run of ones, no repeat while saturated.
- Stuffing: a 0 sampled when the ones counter is exactly 5 is marked stuffed. A mask bit travels with the bit through the DELAY_DEPTH line and the bit is discarded on exit. A 0 after 6 ones is the flag's final bit.
- State IDLE: no byte assembly. Flag -> FRAME, delay line and bit counter cleared, Rx_ValidFrame=1 from the FlagDetect cycle.
- State FRAME, per enabled cycle: the bit exiting the delay line, if not stuffed, shifts into the byte register at the MSB end, shifting right, and the bit counter increments. On the 8th bit: Rx_Data updated and Rx_NewByte=1 in the following cycle; counter wraps to 0.
- FRAME + flag:
  - Bits still in the delay line are flag bits and are discarded.
  - If total payload bits > 0: Rx_FrameEnd=1 in the same cycle as Rx_FlagDetect, and Rx_FrameError=1 too if the residual counter != 0.
  - Shared flag: state stays FRAME (a new frame is opened) and Rx_ValidFrame stays 1.
  - If payload count = 0 (back-to-back flags): no FrameEnd; stays FRAME.
- FRAME + abort: Rx_AbortDetect=1; Rx_ValidFrame=0 in the same cycle; partial byte dropped; no NewByte, FrameEnd or FrameError; -> IDLE.
- Simultaneous 8th bit and flag: cannot occur, because flag bits are still inside the delay line. A NewByte already scheduled is still emitted.
- Rx_Enable=0: no shifting or counting, and pulses are not regenerated. Pulses already registered still fire once.
- Rx_Data holds its value between bytes.

Test Plan:
- Flag, byte 0xA5 (line bits 1,0,1,0,0,1,0,1), flag -> FlagDetect 2 clocks after each flag's last 0; one NewByte with Rx_Data=0xA5; FrameEnd=1; FrameError=0; ValidFrame stays 1.
- Flag, 0xFF sent as 1,1,1,1,1,0,1,1,1, flag -> Rx_Data=0xFF; stuffed 0 removed; exactly one NewByte.
- Flag, 0x3C, then 0 + 7 ones -> AbortDetect 2 clocks after the 7th one; ValidFrame falls; no FrameEnd; a following 0x7E restarts the frame.
- Flag, 0x12, 3 extra bits 1,0,1, flag -> NewByte 0x12; FrameEnd=1 and FrameError=1 together.
- Flag, 0x55, Rst=0 mid-byte, then Rst=1, flag -> all outputs 0 during reset; no FrameEnd; the new flag enters FRAME.
- Flag, 0x81 with Rx_Enable toggling 1/0 each clock -> Rx_Data=0x81; no duplicate pulses; output order identical to the continuous-enable case.
